// File: rtl/rgb_fx_pkg.sv
// Shared mode encodings, channel slice indices and the luma helper for rgb_fx_pipe.
package rgb_fx_pkg;

    localparam logic [3:0] MODE_PASS   = 4'd0;
    localparam logic [3:0] MODE_INV    = 4'd1;
    localparam logic [3:0] MODE_SWAP   = 4'd2;
    localparam logic [3:0] MODE_INV_RB = 4'd3;
    localparam logic [3:0] MODE_MASH1  = 4'd4;
    localparam logic [3:0] MODE_MASH2  = 4'd5;
    localparam logic [3:0] MODE_POST   = 4'd6;
    localparam logic [3:0] MODE_KEY_R  = 4'd7;
    localparam logic [3:0] MODE_KEY_G  = 4'd8;
    localparam logic [3:0] MODE_KEY_B  = 4'd9;
    localparam logic [3:0] MODE_KEY_Y  = 4'd10;
    localparam logic [3:0] MODE_GREY   = 4'd11;

    // Slice index of each channel within the packed {blue, green, red} pixel.
    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;

    localparam int unsigned LUMA_W = 32;

    // Callers zero-extend the channels; the wide sum cannot overflow.
    function automatic logic [LUMA_W-1:0] luma(input logic [LUMA_W-1:0] r,
                                               input logic [LUMA_W-1:0] g,
                                               input logic [LUMA_W-1:0] b);
        return (r + (g << 1) + b) >> 2;
    endfunction

endpackage

// File: rtl/chan_tap_delay.sv
// Per-channel shift line with a selectable tap; tap 0 is the freshest registered sample.
module chan_tap_delay #(
    parameter int unsigned CW      = 8,
    parameter int unsigned MAX_DLY = 16,
    localparam int unsigned DW     = $clog2(MAX_DLY)
) (
    input  logic          pxclk,
    input  logic          rst_n,
    input  logic [CW-1:0] din,
    input  logic [DW-1:0] sel,
    output logic [CW-1:0] dout
);

    logic [CW-1:0] line_q [MAX_DLY];
    logic [CW-1:0] line_d [MAX_DLY];

    always_comb begin
        line_d[0] = din;
        for (int i = 1; i < int'(MAX_DLY); i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_DLY); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q[sel];

endmodule

// File: rtl/rgb_fx_pipe.sv
// Three-stage per-pixel colour effect pipe: input register, per-channel delay, effect/blank.
module rgb_fx_pipe
    import rgb_fx_pkg::*;
#(
    parameter int unsigned CW      = 8,
    parameter int unsigned MAX_DLY = 16,
    localparam int unsigned DW     = $clog2(MAX_DLY),
    localparam int unsigned PW     = $clog2(CW)
) (
    input  logic          pxclk,
    input  logic          rst_n,
    input  logic [3*CW-1:0] vid_pData_in,
    input  logic          vid_pVDE_in,
    input  logic          vid_pHSync_in,
    input  logic          vid_pVSync_in,
    input  logic [3:0]    mode,
    input  logic [CW-1:0] key_thresh,
    input  logic [PW-1:0] post_lvl,
    input  logic [DW-1:0] red_dly,
    input  logic [DW-1:0] green_dly,
    input  logic [DW-1:0] blue_dly,
    output logic [3*CW-1:0] vid_pData_out,
    output logic          vid_pVDE_out,
    output logic          vid_pHSync_out,
    output logic          vid_pVSync_out,
    output logic [3:0]    mode_active
);

    logic [3*CW-1:0] s1_data_q, s1_data_d;
    logic            s1_vde_q, s1_vde_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic            s1_live_q, s1_live_d, armed_q, armed_d;
    logic            s2_vde_q, s2_vde_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
    logic [3:0]      mode_q, mode_d;
    logic [CW-1:0]   thresh_q, thresh_d;
    logic [PW-1:0]   post_q, post_d;
    logic [DW-1:0]   rdly_q, rdly_d, gdly_q, gdly_d, bdly_q, bdly_d;
    logic [3*CW-1:0] s3_data_q, s3_data_d;
    logic            s3_vde_q, s3_vde_d, s3_hs_q, s3_hs_d, s3_vs_q, s3_vs_d;

    logic            frame_edge;
    logic [CW-1:0]   r, g, b, y, fx_r, fx_g, fx_b, post_mask;
    logic            key_pass;

    // s2_vs_q is the previous S1 VSync; armed_q blocks the fake low left behind by reset.
    assign frame_edge = s1_vs_q & ~s2_vs_q & armed_q;

    always_comb begin
        s1_data_d = vid_pData_in;
        s1_vde_d  = vid_pVDE_in;
        s1_hs_d   = vid_pHSync_in;
        s1_vs_d   = vid_pVSync_in;
        s1_live_d = 1'b1;
        armed_d   = armed_q | (s1_live_q & ~s1_vs_q);
        s2_vde_d  = s1_vde_q;
        s2_hs_d   = s1_hs_q;
        s2_vs_d   = s1_vs_q;
        mode_d    = mode_q;
        thresh_d  = thresh_q;
        post_d    = post_q;
        rdly_d    = rdly_q;
        gdly_d    = gdly_q;
        bdly_d    = bdly_q;
        if (frame_edge) begin
            mode_d   = mode;
            thresh_d = key_thresh;
            post_d   = post_lvl;
            rdly_d   = red_dly;
            gdly_d   = green_dly;
            bdly_d   = blue_dly;
        end
    end

    chan_tap_delay #(.CW(CW), .MAX_DLY(MAX_DLY)) u_dly_r (
        .pxclk (pxclk),
        .rst_n (rst_n),
        .din   (s1_data_q[CH_R*CW +: CW]),
        .sel   (rdly_q),
        .dout  (r)
    );

    chan_tap_delay #(.CW(CW), .MAX_DLY(MAX_DLY)) u_dly_g (
        .pxclk (pxclk),
        .rst_n (rst_n),
        .din   (s1_data_q[CH_G*CW +: CW]),
        .sel   (gdly_q),
        .dout  (g)
    );

    chan_tap_delay #(.CW(CW), .MAX_DLY(MAX_DLY)) u_dly_b (
        .pxclk (pxclk),
        .rst_n (rst_n),
        .din   (s1_data_q[CH_B*CW +: CW]),
        .sel   (bdly_q),
        .dout  (b)
    );

    always_comb begin
        y = CW'(luma(LUMA_W'(r), LUMA_W'(g), LUMA_W'(b)));
        for (int unsigned i = 0; i < CW; i++) begin
            post_mask[i] = (i >= 32'(post_q));
        end
        fx_r     = r;
        fx_g     = g;
        fx_b     = b;
        key_pass = 1'b1;
        case (mode_q)
            MODE_PASS:   ;
            MODE_INV:    begin fx_r = ~r; fx_g = ~g; fx_b = ~b; end
            MODE_SWAP:   begin fx_r = g; fx_g = b; fx_b = r; end
            MODE_INV_RB: begin fx_r = ~r; fx_b = ~b; end
            MODE_MASH1:  begin fx_r = b ^ g; fx_g = r; fx_b = g ^ r; end
            MODE_MASH2:  begin fx_r = b ^ g; fx_g = r & g; fx_b = ~r; end
            MODE_POST:   begin
                fx_r = r & post_mask;
                fx_g = g & post_mask;
                fx_b = b & post_mask;
            end
            MODE_KEY_R:  key_pass = r > thresh_q;
            MODE_KEY_G:  key_pass = g > thresh_q;
            MODE_KEY_B:  key_pass = b > thresh_q;
            MODE_KEY_Y:  key_pass = y > thresh_q;
            MODE_GREY:   begin fx_r = y; fx_g = y; fx_b = y; end
            default:     ;
        endcase
        s3_data_d = (s2_vde_q && key_pass) ? {fx_b, fx_g, fx_r} : '0;
        s3_vde_d  = s2_vde_q;
        s3_hs_d   = s2_hs_q;
        s3_vs_d   = s2_vs_q;
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s1_vde_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_live_q <= 1'b0;
            armed_q   <= 1'b0;
            s2_vde_q  <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            mode_q    <= '0;
            thresh_q  <= '0;
            post_q    <= '0;
            rdly_q    <= '0;
            gdly_q    <= '0;
            bdly_q    <= '0;
            s3_data_q <= '0;
            s3_vde_q  <= 1'b0;
            s3_hs_q   <= 1'b0;
            s3_vs_q   <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vde_q  <= s1_vde_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_live_q <= s1_live_d;
            armed_q   <= armed_d;
            s2_vde_q  <= s2_vde_d;
            s2_hs_q   <= s2_hs_d;
            s2_vs_q   <= s2_vs_d;
            mode_q    <= mode_d;
            thresh_q  <= thresh_d;
            post_q    <= post_d;
            rdly_q    <= rdly_d;
            gdly_q    <= gdly_d;
            bdly_q    <= bdly_d;
            s3_data_q <= s3_data_d;
            s3_vde_q  <= s3_vde_d;
            s3_hs_q   <= s3_hs_d;
            s3_vs_q   <= s3_vs_d;
        end
    end

    assign vid_pData_out  = s3_data_q;
    assign vid_pVDE_out   = s3_vde_q;
    assign vid_pHSync_out = s3_hs_q;
    assign vid_pVSync_out = s3_vs_q;
    assign mode_active    = mode_q;

endmodule

// File: tb/tb_rgb_fx_pipe.sv
// Directed bench for rgb_fx_pipe: hand-computed expected pixels checked three edges after input.
module tb_rgb_fx_pipe;

    localparam int unsigned CW = 8;
    localparam int unsigned MAX_DLY = 16;

    logic        pxclk = 1'b0;
    logic        rst_n;
    logic [23:0] vid_pData_in;
    logic        vid_pVDE_in, vid_pHSync_in, vid_pVSync_in;
    logic [3:0]  mode;
    logic [7:0]  key_thresh;
    logic [2:0]  post_lvl;
    logic [3:0]  red_dly, green_dly, blue_dly;
    logic [23:0] vid_pData_out;
    logic        vid_pVDE_out, vid_pHSync_out, vid_pVSync_out;
    logic [3:0]  mode_active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          chk;
        logic [23:0] d;
        logic        vde;
        logic        hs;
        logic        vs;
        string       tag;
    } exp_t;

    exp_t expq[$];

    rgb_fx_pipe #(.CW(CW), .MAX_DLY(MAX_DLY)) dut (
        .pxclk          (pxclk),
        .rst_n          (rst_n),
        .vid_pData_in   (vid_pData_in),
        .vid_pVDE_in    (vid_pVDE_in),
        .vid_pHSync_in  (vid_pHSync_in),
        .vid_pVSync_in  (vid_pVSync_in),
        .mode           (mode),
        .key_thresh     (key_thresh),
        .post_lvl       (post_lvl),
        .red_dly        (red_dly),
        .green_dly      (green_dly),
        .blue_dly       (blue_dly),
        .vid_pData_out  (vid_pData_out),
        .vid_pVDE_out   (vid_pVDE_out),
        .vid_pHSync_out (vid_pHSync_out),
        .vid_pVSync_out (vid_pVSync_out),
        .mode_active    (mode_active)
    );

    always #5 pxclk = ~pxclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one pixel for one edge; the output then shows the pixel driven two calls earlier.
    task automatic drive(input logic [23:0] d, input logic vde, input logic vs,
                         input bit chk, input logic [23:0] ed, input string tag);
        exp_t e;
        vid_pData_in  = d;
        vid_pVDE_in   = vde;
        vid_pHSync_in = ~vde;
        vid_pVSync_in = vs;
        e.chk = chk;
        e.d   = ed;
        e.vde = vde;
        e.hs  = ~vde;
        e.vs  = vs;
        e.tag = tag;
        expq.push_back(e);
        @(posedge pxclk);
        #1;
        if (expq.size() == 3) begin
            e = expq.pop_front();
            if (e.chk) begin
                check({e.tag, "_data"}, {8'h0, vid_pData_out}, {8'h0, e.d});
                check({e.tag, "_sync"}, {29'h0, vid_pVDE_out, vid_pHSync_out, vid_pVSync_out},
                      {29'h0, e.vde, e.hs, e.vs});
            end
        end
    endtask

    // Present new controls and pulse VSync so the shadows pick them up.
    task automatic set_ctrl(input logic [3:0] m, input logic [7:0] th, input logic [2:0] lvl,
                            input logic [3:0] rd);
        mode       = m;
        key_thresh = th;
        post_lvl   = lvl;
        red_dly    = rd;
        drive(24'h0, 1'b0, 1'b1, 1'b1, 24'h0, "vs");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge pxclk);
            #1;
        end
        check("rst_data", {8'h0, vid_pData_out}, 32'h0);
        check("rst_sync", {29'h0, vid_pVDE_out, vid_pHSync_out, vid_pVSync_out}, 32'h0);
        check("rst_mode", {28'h0, mode_active}, 32'h0);
        rst_n = 1'b1;
        expq.delete();
    endtask

    function automatic logic [23:0] ramp(input int k);
        logic [7:0] rr, gg, bb;
        rr = 8'(32'h10 + k);
        gg = 8'(32'h40 + k);
        bb = 8'(32'h80 + k);
        return {bb, gg, rr};
    endfunction

    initial begin
        logic [7:0] red_exp;
        // Controls set to a non-default mode to prove reset ignores them.
        mode          = 4'd11;
        key_thresh    = 8'h0;
        post_lvl      = 3'd0;
        red_dly       = 4'd0;
        green_dly     = 4'd0;
        blue_dly      = 4'd0;
        vid_pData_in  = 24'hFFFFFF;
        vid_pVDE_in   = 1'b1;
        vid_pHSync_in = 1'b1;
        vid_pVSync_in = 1'b0;
        do_reset();

        // Reset defaults are mode 0, zero delay; latency 3.
        drive(24'h000000, 1'b0, 1'b0, 1'b0, 24'h0, "idle");
        drive(24'h112233, 1'b1, 1'b0, 1'b1, 24'h112233, "lat");
        drive(24'h000000, 1'b0, 1'b0, 1'b1, 24'h0, "lat_after");

        // Invert, swap, blanking.
        set_ctrl(4'd1, 8'h0, 3'd0, 4'd0);
        drive(24'h00FF80, 1'b1, 1'b0, 1'b1, 24'hFF007F, "inv");
        set_ctrl(4'd2, 8'h0, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'h113322, "swap");
        drive(24'h332211, 1'b0, 1'b0, 1'b1, 24'h000000, "blank");

        // Shadowing: a mid-frame mode change stays invisible until VSync.
        set_ctrl(4'd0, 8'h0, 3'd0, 4'd0);
        drive(24'h123456, 1'b1, 1'b0, 1'b1, 24'h123456, "sh_pass");
        mode = 4'd1;
        drive(24'h123456, 1'b1, 1'b0, 1'b1, 24'h123456, "sh_mid");
        drive(24'h123456, 1'b1, 1'b0, 1'b1, 24'h123456, "sh_mid2");
        check("mact_mid", {28'h0, mode_active}, 32'h0);
        drive(24'h0, 1'b0, 1'b1, 1'b1, 24'h0, "vs");
        check("mact_pre", {28'h0, mode_active}, 32'h0);
        drive(24'h123456, 1'b1, 1'b0, 1'b1, 24'hEDCBA9, "sh_inv");
        check("mact_post", {28'h0, mode_active}, 32'h1);

        // Remaining bit-level effects on R=11 G=22 B=33.
        set_ctrl(4'd3, 8'h0, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'hCC22EE, "inv_rb");
        set_ctrl(4'd4, 8'h0, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'h331111, "mash1");
        set_ctrl(4'd5, 8'h0, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'hEE0011, "mash2");
        set_ctrl(4'd12, 8'h0, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'h332211, "rsvd");

        // Posterise and keys.
        set_ctrl(4'd6, 8'h0, 3'd4, 4'd0);
        drive(24'hABCDEF, 1'b1, 1'b0, 1'b1, 24'hA0C0E0, "post4");
        set_ctrl(4'd7, 8'h0F, 3'd0, 4'd0);
        drive(24'h55AA0F, 1'b1, 1'b0, 1'b1, 24'h000000, "keyr_eq");
        drive(24'h55AA10, 1'b1, 1'b0, 1'b1, 24'h55AA10, "keyr_gt");
        set_ctrl(4'd8, 8'h22, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'h000000, "keyg_eq");
        set_ctrl(4'd9, 8'h22, 3'd0, 4'd0);
        drive(24'h332211, 1'b1, 1'b0, 1'b1, 24'h332211, "keyb_gt");
        set_ctrl(4'd10, 8'h3F, 3'd0, 4'd0);
        drive(24'h404040, 1'b1, 1'b0, 1'b1, 24'h404040, "keyy_gt");
        set_ctrl(4'd10, 8'h40, 3'd0, 4'd0);
        drive(24'h404040, 1'b1, 1'b0, 1'b1, 24'h000000, "keyy_eq");

        // Greyscale, including the no-wrap full-scale case.
        set_ctrl(4'd11, 8'h0, 3'd0, 4'd0);
        drive(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, "grey_max");
        drive(24'h302010, 1'b1, 1'b0, 1'b1, 24'h202020, "grey_mid");

        // Red delayed by 5 on a ramp; green and blue undelayed.
        set_ctrl(4'd0, 8'h0, 3'd0, 4'd5);
        for (int k = 0; k < 12; k++) begin
            red_exp = 8'(32'h10 + k - 5);
            drive(ramp(k), 1'b1, 1'b0, k >= 5, {ramp(k)[23:8], red_exp}, "dly");
        end

        // Reset mid-ramp: the delay line restarts from zeros.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            red_exp = (k >= 5) ? 8'(32'h10 + k - 5) : 8'h00;
            if (k == 0) begin
                drive(ramp(k), 1'b0, 1'b0, 1'b1, 24'h0, "rdly");
            end else begin
                drive(ramp(k), 1'b1, k == 1, 1'b1, {ramp(k)[23:8], red_exp}, "rdly");
            end
        end
        drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "tail");
        drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
